spiflash_quad_read_ctrl: RTL and testbench

- Read-only sequencer for the W25Q32-class quad SPI boot flash on the spiflash4x pins.
- Accepts word-read requests from the SoC bus bridge and issues Fast Read Quad I/O (0xEB) transactions.
- Returns 32-bit little-endian words.
- Keeps CS_n low across strictly sequential requests to stream without re-issuing command/address.

---
 rtl/spiflash_pkg.sv | 26 ++
 rtl/spiflash_phy_shift.sv | 68 ++++++
 rtl/spiflash_quad_read_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spiflash_quad_read_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_pkg.sv
// Shared constants, state encoding and lane helper for the quad-I/O boot flash reader.
package spiflash_pkg;

   localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;

   localparam logic [3:0] OE_CMD  = 4'b1101;
   localparam logic [3:0] OE_QUAD = 4'hF;
   localparam logic [3:0] OE_IN   = 4'h0;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      MODE,
      DUMMY,
      DATA,
      HOLD,
      CSH
   } state_t;

   // Single-lane phases keep WP/HOLD (dq3/dq2) high and put the bit on dq0.
   function automatic logic [3:0] lane_drive(input logic quad, input logic [31:0] word);
      return quad ? word[31:28] : {2'b11, 1'b0, word[31]};
   endfunction

endpackage

// File: rtl/spiflash_phy_shift.sv
// SCK phase generator with MSB-first shift-out and nibble shift-in.
// One bit-time is a low clk then a high clk; sampling happens on the edge that ends the high phase.
module spiflash_phy_shift
   import spiflash_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        quad,
   input  logic [3:0]  bits,
   input  logic [3:0]  oe,
   input  logic [31:0] data,
   input  logic [3:0]  dq_i,
   output logic        sck,
   output logic [3:0]  dq_o,
   output logic [3:0]  dq_oe,
   output logic [31:0] rx,
   output logic        busy,
   output logic        done
);

   logic [3:0]  cnt;
   logic [31:0] sh;
   logic        quad_q;
   logic [31:0] sh_next;

   assign sh_next = quad_q ? {sh[27:0], 4'h0} : {sh[30:0], 1'b0};
   // Asserted during the last high phase so the next phase can be chained without a gap.
   assign done    = busy & sck & (cnt == 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         sck    <= 1'b0;
         cnt    <= 4'd0;
         sh     <= 32'd0;
         quad_q <= 1'b0;
         dq_o   <= 4'h0;
         dq_oe  <= OE_IN;
         rx     <= 32'd0;
      end else begin
         if (busy && sck) begin
            rx <= {rx[27:0], dq_i};
         end
         if (start) begin
            busy   <= 1'b1;
            sck    <= 1'b0;
            cnt    <= bits;
            sh     <= data;
            quad_q <= quad;
            dq_o   <= lane_drive(quad, data);
            dq_oe  <= oe;
         end else if (busy && !sck) begin
            sck <= 1'b1;
         end else if (busy) begin
            sck <= 1'b0;
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               busy <= 1'b0;
            end else begin
               sh   <= sh_next;
               dq_o <= lane_drive(quad_q, sh_next);
            end
         end
      end
   end

endmodule

// File: rtl/spiflash_quad_read_ctrl.sv
// Word-read sequencer issuing Fast Read Quad I/O (0xEB) to the boot flash,
// streaming strictly sequential words under one CS_n low period.
module spiflash_quad_read_ctrl
   import spiflash_pkg::*;
#(
   parameter int unsigned DUMMY_CLKS = 4,
   parameter int unsigned CSH_CYCLES = 2,
   parameter logic [7:0]  MODE_BYTE  = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        spiflash4x_clk,
   output logic        spiflash4x_cs_n,
   output logic [3:0]  spiflash4x_dq_o,
   output logic [3:0]  spiflash4x_dq_oe,
   input  logic [3:0]  spiflash4x_dq_i
);

   // state | meaning
   // IDLE  | cs_n high, accept a request once the CSH count has expired
   // CMD   | one setup cycle, then 0xEB on dq0
   // ADDR  | 24-bit word address, quad
   // MODE  | continuous-read mode byte, quad
   // DUMMY | turnaround, all lanes released
   // DATA  | 8 nibbles in
   // HOLD  | sck parked low, wait for rsp handshake; stream or release
   // CSH   | cs_n high minimum time

   localparam int CSH_W = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES + 1) : 1;

   state_t             state, state_next;
   logic [21:0]        word_addr;
   logic [21:0]        next_word;
   logic [CSH_W-1:0]   csh_cnt;
   logic               cap;
   logic               seq_match;
   logic               accept;
   logic               stream;
   logic               release_cs;

   logic               start;
   logic               st_quad;
   logic [3:0]         st_bits;
   logic [3:0]         st_oe;
   logic [31:0]        st_data;
   logic               phy_busy;
   logic               phy_done;
   logic [31:0]        phy_rx;

   logic               unused_addr_lsbs;
   assign unused_addr_lsbs = ^req_addr[1:0];

   assign next_word = word_addr + 22'd1;
   assign seq_match = (req_addr[23:2] == next_word);

   spiflash_phy_shift u_phy (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .quad  (st_quad),
      .bits  (st_bits),
      .oe    (st_oe),
      .data  (st_data),
      .dq_i  (spiflash4x_dq_i),
      .sck   (spiflash4x_clk),
      .dq_o  (spiflash4x_dq_o),
      .dq_oe (spiflash4x_dq_oe),
      .rx    (phy_rx),
      .busy  (phy_busy),
      .done  (phy_done)
   );

   always_comb begin
      state_next = state;
      start      = 1'b0;
      st_quad    = 1'b1;
      st_bits    = 4'd8;
      st_oe      = OE_IN;
      st_data    = 32'd0;
      req_ready  = 1'b0;
      accept     = 1'b0;
      stream     = 1'b0;
      release_cs = 1'b0;
      case (state)
         IDLE: begin
            req_ready = (csh_cnt == '0);
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               state_next = CMD;
            end
         end
         CMD: begin
            if (!phy_busy) begin
               start   = 1'b1;
               st_quad = 1'b0;
               st_bits = 4'd8;
               st_oe   = OE_CMD;
               st_data = {CMD_QUAD_IO_READ, 24'd0};
            end else if (phy_done) begin
               state_next = ADDR;
               start      = 1'b1;
               st_bits    = 4'd6;
               st_oe      = OE_QUAD;
               st_data    = {word_addr, 2'b00, 8'd0};
            end
         end
         ADDR: begin
            if (phy_done) begin
               state_next = MODE;
               start      = 1'b1;
               st_bits    = 4'd2;
               st_oe      = OE_QUAD;
               st_data    = {MODE_BYTE, 24'd0};
            end
         end
         MODE: begin
            if (phy_done) begin
               state_next = DUMMY;
               start      = 1'b1;
               st_bits    = 4'(DUMMY_CLKS);
            end
         end
         DUMMY: begin
            if (phy_done) begin
               state_next = DATA;
               start      = 1'b1;
            end
         end
         DATA: begin
            if (phy_done) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            req_ready = rsp_valid && rsp_ready && seq_match;
            if (rsp_valid && rsp_ready) begin
               if (req_valid && seq_match) begin
                  stream     = 1'b1;
                  state_next = DATA;
                  start      = 1'b1;
               end else begin
                  release_cs = 1'b1;
                  state_next = CSH;
               end
            end
         end
         CSH: begin
            if (csh_cnt <= CSH_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         word_addr       <= 22'd0;
         csh_cnt         <= CSH_W'(CSH_CYCLES);
         spiflash4x_cs_n <= 1'b1;
         cap             <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_data        <= 32'd0;
      end else begin
         state <= state_next;
         cap   <= (state == DATA) && phy_done;
         if (accept) begin
            word_addr       <= req_addr[23:2];
            spiflash4x_cs_n <= 1'b0;
         end else if (stream) begin
            word_addr <= next_word;
         end
         if (release_cs) begin
            spiflash4x_cs_n <= 1'b1;
            csh_cnt         <= CSH_W'(CSH_CYCLES);
         end else if (csh_cnt != '0) begin
            csh_cnt <= csh_cnt - CSH_W'(1);
         end
         // Nibbles arrive byte0-first; the word is little-endian.
         if (cap) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {phy_rx[7:0], phy_rx[15:8], phy_rx[23:16], phy_rx[31:24]};
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spiflash_quad_read_ctrl.sv
// Directed bench for spiflash_quad_read_ctrl with a behavioural quad-I/O flash model.
module tb_spiflash_quad_read_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        sck;
   logic        cs_n;
   logic [3:0]  dq_o;
   logic [3:0]  dq_oe;
   logic [3:0]  dq_i;

   spiflash_quad_read_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .spiflash4x_clk   (sck),
      .spiflash4x_cs_n  (cs_n),
      .spiflash4x_dq_o  (dq_o),
      .spiflash4x_dq_oe (dq_oe),
      .spiflash4x_dq_i  (dq_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Flash content: word 0x000100 preloaded with 0x03020100, elsewhere a fixed pattern.
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      if (a[23:2] == 22'h40) return a[7:0];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   int          rcnt = 0;
   int          n_cs_fall = 0;
   int          n_cs_rise = 0;
   int          n_sck = 0;
   logic [7:0]  fcmd;
   logic [7:0]  fmode;
   logic [23:0] faddr;
   logic [3:0]  fcmd_oe;
   time         t_rise = 0;
   time         min_gap = 64'd1000000;

   always @(negedge cs_n) begin
      rcnt = 0;
      n_cs_fall++;
      if ($time - t_rise < min_gap) min_gap = $time - t_rise;
   end

   always @(posedge cs_n) begin
      n_cs_rise++;
      t_rise = $time;
   end

   always @(posedge sck) begin
      n_sck++;
      if (!cs_n) begin
         rcnt++;
         if (rcnt == 1) fcmd_oe = dq_oe;
         if (rcnt <= 8)       fcmd  = {fcmd[6:0], dq_o[0]};
         else if (rcnt <= 14) faddr = {faddr[19:0], dq_o};
         else if (rcnt <= 16) fmode = {fmode[3:0], dq_o};
      end
   end

   always @(negedge sck) begin
      if (!cs_n && rcnt >= 20) begin
         int k;
         logic [23:0] a;
         logic [7:0]  b;
         k = rcnt - 20;
         a = faddr + 24'(4 * (k / 8)) + 24'((k % 8) / 2);
         b = flash_byte(a);
         dq_i = (k % 2 == 0) ? b[7:4] : b[3:0];
      end
   end

   task automatic issue(input logic [23:0] a, output int acc);
      acc = -1;
      req_valid = 1'b1;
      req_addr  = a;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (req_ready) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("accept", 32'(acc >= 0), 32'd1);
   endtask

   task automatic wait_rsp(output int v);
      v = -1;
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid) begin
            v = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic handshake(input logic [23:0] na, input logic nv, output int hs, output logic rdy);
      rsp_ready = 1'b1;
      req_valid = nv;
      req_addr  = na;
      #1;
      rdy = req_ready;
      hs  = cyc + 1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic release_check(input string name);
      logic seen;
      seen = cs_n;
      if (!seen) begin
         @(negedge clk);
         seen = cs_n;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   typedef struct {
      logic [23:0] addr;
      logic [31:0] exp_data;
      logic [23:0] exp_faddr;
   } vec_t;

   vec_t vt[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   acc, v, hs, f0, r0, s0;
      logic rdy;
      logic [31:0] d0;

      vt[0] = '{24'h000100, 32'h03020100, 24'h000100};
      vt[1] = '{24'h000010, 32'h49484B4A, 24'h000010};
      vt[2] = '{24'h000040, 32'h19181B1A, 24'h000040};
      vt[3] = '{24'h000203, 32'h5B5A5958, 24'h000200};
      vt[4] = '{24'hFFFFFC, 32'hA5A4A7A6, 24'hFFFFFC};

      reset = 1'b1; req_valid = 1'b0; req_addr = 24'd0; rsp_ready = 1'b0; dq_i = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_dq_oe", 32'(dq_oe), 32'd0);
      chk("rst_dq_o", 32'(dq_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("csh_preload_ready", 32'(req_ready), 32'd0);
      @(negedge clk);

      // Single non-sequential reads, each with its own command phase.
      for (int i = 0; i < 5; i++) begin
         f0 = n_cs_fall;
         issue(vt[i].addr, acc);
         wait_rsp(v);
         chk($sformatf("v%0d_data", i), rsp_data, vt[i].exp_data);
         chk($sformatf("v%0d_latency", i), 32'(v - acc), 32'd58);
         chk($sformatf("v%0d_cmd", i), 32'(fcmd), 32'hEB);
         chk($sformatf("v%0d_cmd_oe", i), 32'(fcmd_oe), 32'hD);
         chk($sformatf("v%0d_addr", i), 32'(faddr), 32'(vt[i].exp_faddr));
         chk($sformatf("v%0d_mode", i), 32'(fmode), 32'hFF);
         handshake(24'd0, 1'b0, hs, rdy);
         release_check($sformatf("v%0d_cs_release", i));
         chk($sformatf("v%0d_one_cmd", i), 32'(n_cs_fall - f0), 32'd1);
      end

      // Sequential burst 0, 4, 8 under a single CS_n low period.
      f0 = n_cs_fall;
      r0 = n_cs_rise;
      issue(24'h000000, acc);
      wait_rsp(v);
      chk("burst0_data", rsp_data, 32'h59585B5A);
      chk("burst0_latency", 32'(v - acc), 32'd58);
      handshake(24'h000004, 1'b1, hs, rdy);
      chk("burst1_ready", 32'(rdy), 32'd1);
      wait_rsp(v);
      chk("burst1_data", rsp_data, 32'h5D5C5F5E);
      chk("burst1_latency", 32'(v - hs), 32'd17);
      handshake(24'h000008, 1'b1, hs, rdy);
      chk("burst2_ready", 32'(rdy), 32'd1);
      wait_rsp(v);
      chk("burst2_data", rsp_data, 32'h51505352);
      chk("burst2_latency", 32'(v - hs), 32'd17);
      chk("burst_no_cs_toggle", 32'(n_cs_rise - r0), 32'd0);
      chk("burst_one_cmd", 32'(n_cs_fall - f0), 32'd1);
      handshake(24'h000040, 1'b1, hs, rdy);
      chk("nonseq_hold_ready", 32'(rdy), 32'd0);
      release_check("burst_cs_release");

      // Back-pressure on the first word of a burst.
      issue(24'h000100, acc);
      wait_rsp(v);
      s0 = n_sck;
      d0 = rsp_data;
      repeat (20) @(negedge clk);
      chk("bp_sck_frozen", 32'(n_sck - s0), 32'd0);
      chk("bp_sck_low", 32'(sck), 32'd0);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_data_stable", rsp_data, d0);
      handshake(24'h000104, 1'b1, hs, rdy);
      chk("bp_stream_ready", 32'(rdy), 32'd1);
      wait_rsp(v);
      chk("bp_second_data", rsp_data, 32'h5C5D5E5F);
      chk("bp_second_latency", 32'(v - hs), 32'd17);
      handshake(24'd0, 1'b0, hs, rdy);
      release_check("bp_cs_release");

      // Address wrap 0xFFFFFC -> 0x000000 streams without CS toggle.
      issue(24'hFFFFFC, acc);
      wait_rsp(v);
      chk("wrap_first_data", rsp_data, 32'hA5A4A7A6);
      r0 = n_cs_rise;
      handshake(24'h000000, 1'b1, hs, rdy);
      chk("wrap_stream_ready", 32'(rdy), 32'd1);
      wait_rsp(v);
      chk("wrap_second_data", rsp_data, 32'h59585B5A);
      chk("wrap_no_cs_toggle", 32'(n_cs_rise - r0), 32'd0);
      handshake(24'd0, 1'b0, hs, rdy);
      release_check("wrap_cs_release");

      // Reset in the middle of the address phase.
      issue(24'h000010, acc);
      repeat (20) @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 24'h000300;
      #1;
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      chk("mid_addr_sck_high", 32'(sck), 32'd1);
      req_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(cs_n), 32'd1);
      chk("midrst_dq_oe", 32'(dq_oe), 32'd0);
      chk("midrst_sck", 32'(sck), 32'd0);
      chk("midrst_dq_o", 32'(dq_o), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(24'h000200, acc);
      wait_rsp(v);
      chk("postrst_data", rsp_data, 32'h5B5A5958);
      chk("postrst_addr", 32'(faddr), 32'h000200);
      chk("postrst_latency", 32'(v - acc), 32'd58);
      handshake(24'd0, 1'b0, hs, rdy);
      release_check("postrst_cs_release");

      chk("csh_min_gap_ge2", 32'(min_gap >= 20), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
